mult_seq_ctrl: RTL and testbench



---
 rtl/mult_seq_ctrl.sv | 117 +++++++++++
 tb/tb_mult_seq_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// Sequential shift-and-add unsigned multiplier: one partial-product step per clock,
// WIDTH steps per operation, product and overflow flag delivered with a one-cycle done pulse.
module mult_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] s,
  output logic               cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH:0]       a_q, a_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   s_q, s_d;
  logic                 cout_q, cout_d;
  logic [WIDTH:0]       sum;

  // A's top bit is always zero after the shift, so adding the full register
  // gives the same WIDTH+1-bit sum as adding only its lower WIDTH bits.
  assign sum = a_q + {1'b0, (q_q[0] ? m_q : '0)};

  always_comb begin
    // NOTE: every _d gets a default from its _q first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    s_d     = s_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = b;
          q_d     = c;
          a_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        // Right shift of carry:sum:Q; the carry lands in A's MSB-1 and is never lost.
        a_d   = {1'b0, sum[WIDTH:1]};
        q_d   = {sum[0], q_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          s_d     = {sum, q_q[WIDTH-1:1]};
          cout_d  = |sum[WIDTH:1];
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      a_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed vector table, corner-case
// sequences (ignored start, mid-operation reset, held start) and random operands.
module tb_mult_seq_ctrl;

  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   b;
  logic [W-1:0]   c;
  logic           busy;
  logic           done;
  logic [2*W-1:0] s;
  logic           cout;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic [W-1:0]   b;
    logic [W-1:0]   c;
    logic [2*W-1:0] s;
    logic           cout;
  } vec_t;

  vec_t vecs[7];

  mult_seq_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .b    (b),
    .c    (c),
    .busy (busy),
    .done (done),
    .s    (s),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from IDLE and check busy width, latency, result and done width.
  task automatic run_op(input logic [W-1:0] bb, input logic [W-1:0] cc,
                        input logic [2*W-1:0] es, input logic ec, input string name);
    int lat;
    int busy_cnt;
    start = 1'b1;
    b     = bb;
    c     = cc;
    step();
    start = 1'b0;
    b     = W'($urandom);
    c     = W'($urandom);
    lat      = 0;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      step();
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(W));
    check({name, " busy cycles"}, 32'(busy_cnt), 32'(W));
    check({name, " s"}, 32'(s), 32'(es));
    check({name, " cout"}, 32'(cout), 32'(ec));
    step();
    check({name, " done width"}, 32'(done), 32'd0);
    check({name, " s hold"}, 32'(s), 32'(es));
  endtask

  initial begin
    int gap;
    int seen;
    logic [W-1:0]   rb;
    logic [W-1:0]   rc;
    logic [2*W-1:0] prod;

    n_cmp  = 0;
    n_fail = 0;

    vecs[0] = '{b: 4'd5,  c: 4'd6,  s: 8'h1E, cout: 1'b1};
    vecs[1] = '{b: 4'd1,  c: 4'd1,  s: 8'h01, cout: 1'b0};
    vecs[2] = '{b: 4'd2,  c: 4'd1,  s: 8'h02, cout: 1'b0};
    vecs[3] = '{b: 4'd15, c: 4'd15, s: 8'hE1, cout: 1'b1};
    vecs[4] = '{b: 4'd0,  c: 4'd9,  s: 8'h00, cout: 1'b0};
    vecs[5] = '{b: 4'd9,  c: 4'd0,  s: 8'h00, cout: 1'b0};
    vecs[6] = '{b: 4'd7,  c: 4'd3,  s: 8'h15, cout: 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    b     = '0;
    c     = '0;
    step();
    step();
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset s",    32'(s),    32'd0);
    check("reset cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].b, vecs[i].c, vecs[i].s, vecs[i].cout, $sformatf("vec%0d", i));
    end

    // Start pulses and operand changes during CALC are ignored.
    start = 1'b1; b = 4'd5; c = 4'd6;
    step();
    start = 1'b0;
    step();
    start = 1'b1; b = 4'd3; c = 4'd3;
    step();
    start = 1'b0; b = 4'd12; c = 4'd13;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) begin
        seen++;
        check("ignored start s", 32'(s), 32'h1E);
      end
      step();
    end
    check("ignored start done count", 32'(seen), 32'd1);

    // Asynchronous reset in the middle of CALC.
    start = 1'b1; b = 4'd9; c = 4'd9;
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst s",    32'(s),    32'd0);
    check("async rst cout", 32'(cout), 32'd0);
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) seen++;
      step();
    end
    check("no done after reset", 32'(seen), 32'd0);
    run_op(4'd7, 4'd3, 8'h15, 1'b1, "post reset");

    // Held start: next acceptance comes on the first IDLE edge after DONE.
    start = 1'b1; b = 4'd2; c = 4'd3;
    gap = 0;
    for (int k = 0; k < 20 && !done; k++) step();
    check("held first done", 32'(done), 32'd1);
    step();
    gap = 1;
    while (!done && gap < 30) begin
      step();
      gap++;
    end
    check("held issue interval", 32'(gap), 32'(W + 2));
    check("held s", 32'(s), 32'd6);
    start = 1'b0;
    for (int k = 0; k < 2 * W + 4; k++) step();
    check("held drained busy", 32'(busy), 32'd0);

    // Random operands against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      rb   = W'($urandom);
      rc   = W'($urandom);
      prod = (2*W)'(int'(rb) * int'(rc));
      run_op(rb, rc, prod, (prod >> W) != 0, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
